bcd_scan_ctrl: RTL and testbench

Memory-mapped scan controller for the four-digit seven-segment display on the CPU peripheral bus. Software writes a 16-bit hex value plus control bits. The block time-multiplexes the digits, decodes each nibble to segments, and inserts a blanking gap between digits. Display data is double-buffered so a write never tears a frame mid-scan.

---
 rtl/bcd_scan_ctrl_if.sv | 25 ++
 rtl/bcd_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_ctrl_if.sv
// Peripheral bus seen by the seven-segment scan controller.
// Read_data is combinational on the slave side and is zero unless StatusRead is high.
interface bcd_scan_ctrl_if;
    logic        StatusRead;
    logic        StatusWrite;
    logic [1:0]  Addr;
    logic [31:0] Write_data;
    logic [31:0] Read_data;

    modport master (
        output StatusRead,
        output StatusWrite,
        output Addr,
        output Write_data,
        input  Read_data
    );

    modport slave (
        input  StatusRead,
        input  StatusWrite,
        input  Addr,
        input  Write_data,
        output Read_data
    );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// Four-digit seven-segment scan controller.
// Software writes a pending 16-bit value. The value is copied to the displayed (active)
// copy only at a frame boundary, so a frame never shows a mix of old and new digits.
// The sel/seg outputs come from flops. They are computed from next-state values, so
// after any edge they match the div/idx/ctrl/active values now held in the flops.
module bcd_scan_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int DEAD    = 1
) (
    input  logic               clk,
    input  logic               reset,
    bcd_scan_ctrl_if.slave     bus,
    output logic [3:0]         sel,
    output logic [7:0]         seg
);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DEAD_V  = DIV_W'(DEAD);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    // ctrl layout: [11:8] blank mask, [7:4] dp mask, [3:1] always zero, [0] enable
    logic [15:0]      pending_q, pending_d;
    logic [15:0]      active_q, active_d;
    logic [11:0]      ctrl_q, ctrl_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       sel_q, sel_d;
    logic [7:0]       seg_q, seg_d;
    logic             wrap;

    logic unused_wdata;
    assign unused_wdata = ^bus.Write_data[31:16];

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Register reads: combinational from current flop state, so a write shows up the next cycle
    always_comb begin
        bus.Read_data = 32'b0;
        if (bus.StatusRead) begin
            case (bus.Addr)
                ADDR_DATA:   bus.Read_data = {16'b0, pending_q};
                ADDR_CTRL:   bus.Read_data = {20'b0, ctrl_q};
                ADDR_STATUS: bus.Read_data = {29'b0, (pending_q != active_q), idx_q};
                default:     bus.Read_data = 32'b0;
            endcase
        end
    end

    // Next-state logic: register writes, the scan counters, the frame latch and the output patterns
    always_comb begin
        pending_d = pending_q;
        ctrl_d    = ctrl_q;
        if (bus.StatusWrite) begin
            if (bus.Addr == ADDR_DATA) pending_d = bus.Write_data[15:0];
            if (bus.Addr == ADDR_CTRL) ctrl_d = {bus.Write_data[11:4], 3'b000, bus.Write_data[0]};
        end

        // counting only when enable was and stays set; any enable edge restarts at slot 0
        div_d = '0;
        idx_d = 2'd0;
        wrap  = 1'b0;
        if (ctrl_q[0] && ctrl_d[0]) begin
            if (div_q == DIV_MAX) begin
                idx_d = idx_q + 2'd1;
                wrap  = (idx_q == 2'd3);
            end else begin
                div_d = div_q + 1'b1;
                idx_d = idx_q;
            end
        end

        // pending_d already carries a same-cycle DATA write, so that write wins at the wrap
        active_d = active_q;
        if (!ctrl_q[0] || wrap) active_d = pending_d;

        sel_d = 4'b0000;
        seg_d = 8'hFF;
        if (ctrl_d[0] && (div_d >= DEAD_V)) begin
            sel_d = 4'b0001 << idx_d;
            if (!ctrl_d[8 + idx_d]) begin
                seg_d = {~ctrl_d[4 + idx_d], decode(active_d[{idx_d, 2'b00} +: 4])};
            end
        end
    end

    // State and output flops, cleared asynchronously so the display goes dark at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= 16'h0000;
            active_q  <= 16'h0000;
            ctrl_q    <= 12'h000;
            div_q     <= '0;
            idx_q     <= 2'd0;
            sel_q     <= 4'b0000;
            seg_q     <= 8'hFF;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            ctrl_q    <= ctrl_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            seg_q     <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;
endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed bench for bcd_scan_ctrl with CLK_DIV=4 and DEAD=1. A digit slot is one dark cycle
// followed by three lit cycles. The counter k is the number of edges since enable went high.
module tb_bcd_scan_ctrl;
    logic       clk;
    logic       reset;
    logic [3:0] sel;
    logic [7:0] seg;
    int         n_total;
    int         n_pass;
    logic [7:0] frame0 [4];

    bcd_scan_ctrl_if bus ();

    bcd_scan_ctrl #(.CLK_DIV(4), .DEAD(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .sel   (sel),
        .seg   (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        bus.StatusWrite = 1'b1;
        bus.Addr        = a;
        bus.Write_data  = d;
        tick();
        bus.StatusWrite = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.StatusRead = 1'b1;
        bus.Addr       = a;
        #1;
        chk(tag, bus.Read_data, exp);
        bus.StatusRead = 1'b0;
    endtask

    task automatic out_chk(input string tag, input logic [3:0] es, input logic [7:0] eg);
        chk({tag, "_sel"}, {28'b0, sel}, {28'b0, es});
        chk({tag, "_seg"}, {24'b0, seg}, {24'b0, eg});
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        // 1A08: digit0=8, digit1=0, digit2=A, digit3=1, dp off
        frame0[0] = 8'h80;
        frame0[1] = 8'hC0;
        frame0[2] = 8'h88;
        frame0[3] = 8'hF9;
        bus.StatusRead  = 1'b0;
        bus.StatusWrite = 1'b0;
        bus.Addr        = 2'd0;
        bus.Write_data  = 32'b0;
        reset = 1'b0;
        tick_n(2);
        out_chk("reset_out", 4'b0000, 8'hFF);
        reset = 1'b1;
        tick();
        rd_chk("reset_data", 2'd0, 32'h0);
        rd_chk("reset_ctrl", 2'd1, 32'h0);
        rd_chk("reset_status", 2'd2, 32'h0);
        chk("read_idle_zero", bus.Read_data, 32'h0);

        // unused CTRL bits read zero; the reserved address ignores writes
        bus_wr(2'd1, 32'hFFFF_FFFE);
        rd_chk("ctrl_mask", 2'd1, 32'h0000_0FF0);
        bus_wr(2'd1, 32'h0);
        bus_wr(2'd3, 32'hFFFF_FFFF);
        rd_chk("reserved", 2'd3, 32'h0);
        out_chk("disabled_dark", 4'b0000, 8'hFF);

        bus_wr(2'd0, 32'hDEAD_1A08);
        rd_chk("data_rd", 2'd0, 32'h0000_1A08);

        // enable write; a read in the same cycle still sees the old CTRL value
        bus.StatusWrite = 1'b1;
        bus.Addr        = 2'd1;
        bus.Write_data  = 32'h1;
        bus.StatusRead  = 1'b1;
        #1;
        chk("ctrl_same_cycle_old", bus.Read_data, 32'h0);
        bus.StatusRead  = 1'b0;
        tick();
        bus.StatusWrite = 1'b0;
        // k=0 after the enable edge; walk one full frame
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick();
            if (k % 4 == 0) out_chk("frame0_dead", 4'b0000, 8'hFF);
            else out_chk("frame0_lit", 4'b0001 << (k / 4), frame0[k / 4]);
        end
        rd_chk("ctrl_rd_en", 2'd1, 32'h1);

        // k=15 -> k=20 (digit 1, dark cycle); DATA write lands at the edge into k=21
        tick_n(5);
        bus_wr(2'd0, 32'h0000_FFFF);
        out_chk("buffered_d1", 4'b0010, 8'hC0);
        rd_chk("status_pend_d1", 2'd2, 32'h5);
        tick_n(4);
        out_chk("buffered_d2", 4'b0100, 8'h88);
        tick_n(4);
        out_chk("buffered_d3", 4'b1000, 8'hF9);
        rd_chk("status_pend_d3", 2'd2, 32'h7);
        tick_n(3);
        out_chk("wrap_dead", 4'b0000, 8'hFF);
        rd_chk("status_after_wrap", 2'd2, 32'h0);
        tick();
        out_chk("new_frame_d0", 4'b0001, 8'h8E);
        tick_n(4);
        out_chk("new_frame_d1", 4'b0010, 8'h8E);

        // k=37 -> k=47; DATA write on the 3->0 wrap edge is shown in the frame that starts
        tick_n(10);
        bus_wr(2'd0, 32'h0000_0005);
        out_chk("wrap_wr_dead", 4'b0000, 8'hFF);
        tick();
        out_chk("wrap_wr_d0", 4'b0001, 8'h92);
        rd_chk("wrap_wr_status", 2'd2, 32'h0);
        tick_n(4);
        out_chk("wrap_wr_d1", 4'b0010, 8'hC0);

        // k=53 -> k=63; CTRL=0x211: dp on digit 0, blank digit 1
        tick_n(10);
        bus_wr(2'd1, 32'h0000_0211);
        tick();
        out_chk("dp_d0", 4'b0001, 8'h12);
        tick_n(4);
        out_chk("blank_d1", 4'b0010, 8'hFF);
        rd_chk("ctrl_rd_masks", 2'd1, 32'h211);
        tick();
        bus_wr(2'd1, 32'h0);
        out_chk("disable_mid_slot", 4'b0000, 8'hFF);
        rd_chk("disable_status", 2'd2, 32'h0);
        tick_n(2);
        out_chk("disabled_stays_dark", 4'b0000, 8'hFF);

        // re-enable, then pulse reset between edges
        bus_wr(2'd1, 32'h1);
        out_chk("reenable_dead", 4'b0000, 8'hFF);
        tick();
        out_chk("reenable_d0", 4'b0001, 8'h92);
        #2;
        reset = 1'b0;
        #1;
        out_chk("async_reset", 4'b0000, 8'hFF);
        tick();
        reset = 1'b1;
        rd_chk("post_reset_data", 2'd0, 32'h0);
        rd_chk("post_reset_ctrl", 2'd1, 32'h0);
        rd_chk("post_reset_status", 2'd2, 32'h0);
        tick_n(6);
        out_chk("post_reset_dark", 4'b0000, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
